multicycle_ctrl: RTL
====================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 16: cycles to wait for mem_ack before trapping (legal range 1..255).
REQ-002 clk  input  1  the single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 instr  input  32  instruction word; fields op=[31:26], funct=[5:0].
REQ-005 instr_valid  input  1  instr is valid this cycle.
REQ-006 instr_ready  output  1  controller accepts instr this cycle.
REQ-007 alu_zero  input  1  ALU zero flag (result == 0).
REQ-008 alu_op  output  3  ALU operation: 0 add, 1 noop, 2 and, 3 or, 4 slt, 5 sll, 6 eq-compare (0 when equal), 7 ne-compare (0 when not equal).
REQ-009 alu_src_b  output  2  ALU B select: 0 register, 1 sign-extended imm, 2 zero.
REQ-010 mem_req, mem_we  output  1 each  data-memory request and write strobe.
REQ-011 mem_ack  input  1  memory completion, one-cycle pulse.
REQ-012 reg_we, reg_dst, mem_to_reg  output  1 each  register write enable, dest select (1 = rd, 0 = rt), writeback source (1 = memory).
REQ-013 pc_we  output  1  PC update strobe.
REQ-014 pc_src  output  2  0 = PC+4, 1 = branch target, 2 = jump target.
REQ-015 trap  output  1  sticky illegal-instruction or memory-timeout flag.

Function
REQ-016 States: FETCH, DECODE, EXEC, MEM, WB, BRANCH, JUMP, TRAP; one state per cycle, except FETCH and MEM, which hold.
REQ-017 FETCH: instr_ready=1; on instr_valid, latch instr into an internal register and go to DECODE; otherwise hold.
REQ-018 DECODE: classify the latched instr; illegal op/funct goes to TRAP; j goes to JUMP; beq/bne go to BRANCH; all others go to EXEC.
REQ-019 R-type (op 0x00): funct 0x20 add->0, 0x24 and->2, 0x25 or->3, 0x2A slt->4, 0x00 sll->5; alu_src_b=0; reg_dst=1.
REQ-020 addi 0x08, lw 0x23, sw 0x2B: alu_op=0, alu_src_b=1; addi/lw use reg_dst=0.
REQ-021 EXEC: drive alu_op/alu_src_b for exactly 1 cycle; lw/sw go to MEM, others go to WB.
REQ-022 MEM: mem_req=1 (mem_we=1 for sw) held until mem_ack; lw then goes to WB, sw goes to FETCH with pc_we=1, pc_src=0 in the ack cycle.
REQ-023 The MEM wait counter resets on MEM entry; if MEM_TIMEOUT cycles pass without mem_ack, drop mem_req and go to TRAP.
REQ-024 mem_ack arriving in the same cycle as timeout expiry counts as success.
REQ-025 WB: reg_we=1 for 1 cycle, mem_to_reg=1 for lw only, pc_we=1, pc_src=0; go to FETCH.
REQ-026 BRANCH: beq drives alu_op=6, bne drives alu_op=7, alu_src_b=0; pc_we=1 in all cases; pc_src=1 if alu_zero, else 0; go to FETCH.
REQ-027 JUMP: pc_we=1, pc_src=2; go to FETCH.
REQ-028 TRAP: trap=1, all strobes 0, instr_ready=0; leave only by reset.
REQ-029 Outside the states named above, strobes are 0, alu_op=1 (noop), and alu_src_b=0.
REQ-030 Instruction latency (FETCH accept to pc_we): R/addi 3 cycles, branch/jump 2 cycles, lw 4+wait cycles, sw 3+wait cycles.
REQ-031 Back-to-back: a new instr is accepted the cycle after pc_we.

Reset
REQ-032 rst_n low, including mid-instruction or mid-MEM, forces FETCH immediately.
REQ-033 During reset, all outputs are 0 except alu_op=1; trap, the latched instr and the wait counter clear.
REQ-034 The first instr_ready=1 is asserted in the first cycle after rst_n deasserts.

Structure
REQ-035 Shared package ctrl_pkg holds: ALU op encodings, opcode/funct constants, the state enum and the pc_src encoding.
REQ-036 One sub-module, instr_decode, is combinational and maps op/funct to instruction class, alu_op and an illegal flag.

Verification
REQ-037 add (op 0, funct 0x20) with instr_valid=1 -> DECODE, EXEC alu_op=0, then WB with reg_we=1, reg_dst=1, pc_we=1; instr_ready again at cycle 4.
REQ-038 beq with alu_zero=1 -> BRANCH alu_op=6, pc_we=1, pc_src=1; repeated with alu_zero=0 -> pc_src=0.
REQ-039 lw with mem_ack after 3 cycles -> mem_req high exactly 3 cycles, then WB with mem_to_reg=1, reg_dst=0.
REQ-040 sw with MEM_TIMEOUT=4 and no mem_ack -> mem_req for 4 cycles, then trap=1 and instr_ready held 0.
REQ-041 op 0x3F -> trap=1 after DECODE; rst_n pulse low then high -> trap=0, instr_ready=1.
REQ-042 rst_n low during MEM wait -> mem_req=0 immediately; first instr_ready=1 in the first cycle after rst_n deasserts.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and constants for the multicycle controller: ALU op, ALU B
// select, PC source encodings, FSM states, instruction classes and the
// opcode/funct values recognised by the decoder.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_NOOP = 3'd1,
    ALU_AND  = 3'd2,
    ALU_OR   = 3'd3,
    ALU_SLT  = 3'd4,
    ALU_SLL  = 3'd5,
    ALU_EQ   = 3'd6,
    ALU_NE   = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    SRCB_REG  = 2'd0,
    SRCB_IMM  = 2'd1,
    SRCB_ZERO = 2'd2
  } alu_src_b_e;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JUMP   = 2'd2
  } pc_src_e;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_BRANCH,
    S_JUMP,
    S_TRAP
  } state_e;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_ADDI,
    CLS_LW,
    CLS_SW,
    CLS_BEQ,
    CLS_BNE,
    CLS_J,
    CLS_ILL
  } instr_class_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // Memory wait counter width; covers MEM_TIMEOUT up to 255.
  localparam int unsigned WAIT_W = 8;

  function automatic logic is_mem_class(input instr_class_e c);
    return (c == CLS_LW) || (c == CLS_SW);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Instruction handshake, ALU, memory and PC control bundle of the multicycle
// controller. slave = controller side, master = environment side.
interface multicycle_ctrl_if;

  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        alu_zero;
  logic [2:0]  alu_op;
  logic [1:0]  alu_src_b;
  logic        mem_req;
  logic        mem_we;
  logic        mem_ack;
  logic        reg_we;
  logic        reg_dst;
  logic        mem_to_reg;
  logic        pc_we;
  logic [1:0]  pc_src;
  logic        trap;

  modport slave (
    input  instr, instr_valid, alu_zero, mem_ack,
    output instr_ready, alu_op, alu_src_b, mem_req, mem_we,
           reg_we, reg_dst, mem_to_reg, pc_we, pc_src, trap
  );

  modport master (
    output instr, instr_valid, alu_zero, mem_ack,
    input  instr_ready, alu_op, alu_src_b, mem_req, mem_we,
           reg_we, reg_dst, mem_to_reg, pc_we, pc_src, trap
  );

endinterface

// File: rtl/multicycle_ctrl_instr_decode.sv
// Combinational instruction decoder: op/funct -> instruction class, ALU op and
// illegal flag. Anything not explicitly listed is illegal.
module instr_decode
  import ctrl_pkg::*;
(
  input  logic [5:0]   i_op,
  input  logic [5:0]   i_funct,
  output instr_class_e o_class,
  output alu_op_e      o_alu_op,
  output logic         o_illegal
);

  // Classify opcode, and funct for R-type; unknown encodings fall to CLS_ILL
  always_comb begin
    o_class  = CLS_ILL;
    o_alu_op = ALU_NOOP;
    case (i_op)
      OP_RTYPE: begin
        o_class = CLS_R;
        case (i_funct)
          FN_ADD:  o_alu_op = ALU_ADD;
          FN_AND:  o_alu_op = ALU_AND;
          FN_OR:   o_alu_op = ALU_OR;
          FN_SLT:  o_alu_op = ALU_SLT;
          FN_SLL:  o_alu_op = ALU_SLL;
          default: o_class  = CLS_ILL;
        endcase
      end
      OP_ADDI: begin
        o_class  = CLS_ADDI;
        o_alu_op = ALU_ADD;
      end
      OP_LW: begin
        o_class  = CLS_LW;
        o_alu_op = ALU_ADD;
      end
      OP_SW: begin
        o_class  = CLS_SW;
        o_alu_op = ALU_ADD;
      end
      OP_BEQ: begin
        o_class  = CLS_BEQ;
        o_alu_op = ALU_EQ;
      end
      OP_BNE: begin
        o_class  = CLS_BNE;
        o_alu_op = ALU_NE;
      end
      OP_J:    o_class = CLS_J;
      default: o_class = CLS_ILL;
    endcase
  end

  assign o_illegal = (o_class == CLS_ILL);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle instruction controller: FETCH/DECODE/EXEC/MEM/WB/BRANCH/JUMP/TRAP
// sequencer driving ALU, memory, register-file and PC strobes.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  multicycle_ctrl_if.slave bus
);

  localparam logic [WAIT_W-1:0] TIMEOUT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_e              r_state;
  logic [31:0]         r_instr;
  logic [WAIT_W-1:0]   r_wait;
  logic                r_instr_ready;
  alu_op_e             r_alu_op;
  alu_src_b_e          r_alu_src_b;
  logic                r_mem_req;
  logic                r_mem_we;
  logic                r_reg_we;
  logic                r_reg_dst;
  logic                r_mem_to_reg;
  logic                r_pc_we;
  pc_src_e             r_pc_src;
  logic                r_trap;

  instr_class_e        w_class;
  alu_op_e             w_dec_alu_op;
  logic                w_illegal;
  logic                w_is_sw;
  logic                w_timeout;
  logic                w_sw_ack;
  logic [1:0]          w_pc_src;
  logic                w_unused_fields;

  instr_decode u_decode (
    .i_op      (r_instr[31:26]),
    .i_funct   (r_instr[5:0]),
    .o_class   (w_class),
    .o_alu_op  (w_dec_alu_op),
    .o_illegal (w_illegal)
  );

  assign w_is_sw         = (w_class == CLS_SW);
  assign w_timeout       = (r_wait == TIMEOUT_LAST);
  assign w_unused_fields = ^r_instr[25:6];

  // Sequencer: each branch loads state and the outputs for the next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_FETCH;
      r_instr       <= '0;
      r_wait        <= '0;
      r_instr_ready <= 1'b0;
      r_alu_op      <= ALU_NOOP;
      r_alu_src_b   <= SRCB_REG;
      r_mem_req     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_reg_we      <= 1'b0;
      r_reg_dst     <= 1'b0;
      r_mem_to_reg  <= 1'b0;
      r_pc_we       <= 1'b0;
      r_pc_src      <= PC_PLUS4;
      r_trap        <= 1'b0;
    end else begin
      r_instr_ready <= 1'b0;
      r_alu_op      <= ALU_NOOP;
      r_alu_src_b   <= SRCB_REG;
      r_mem_req     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_reg_we      <= 1'b0;
      r_reg_dst     <= 1'b0;
      r_mem_to_reg  <= 1'b0;
      r_pc_we       <= 1'b0;
      r_pc_src      <= PC_PLUS4;
      case (r_state)
        S_FETCH: begin
          // ready is registered, so the first cycle out of reset only raises it
          if (r_instr_ready && bus.instr_valid) begin
            r_instr <= bus.instr;
            r_state <= S_DECODE;
          end else begin
            r_instr_ready <= 1'b1;
          end
        end
        S_DECODE: begin
          if (w_illegal) begin
            r_state <= S_TRAP;
            r_trap  <= 1'b1;
          end else if (w_class == CLS_J) begin
            r_state  <= S_JUMP;
            r_pc_we  <= 1'b1;
            r_pc_src <= PC_JUMP;
          end else if (w_class == CLS_BEQ || w_class == CLS_BNE) begin
            r_state  <= S_BRANCH;
            r_alu_op <= w_dec_alu_op;
            r_pc_we  <= 1'b1;
          end else begin
            r_state  <= S_EXEC;
            r_alu_op <= w_dec_alu_op;
            if (w_class != CLS_R) begin
              r_alu_src_b <= SRCB_IMM;
            end
          end
        end
        S_EXEC: begin
          if (is_mem_class(w_class)) begin
            r_state   <= S_MEM;
            r_wait    <= '0;
            r_mem_req <= 1'b1;
            r_mem_we  <= w_is_sw;
          end else begin
            r_state   <= S_WB;
            r_reg_we  <= 1'b1;
            r_reg_dst <= (w_class == CLS_R);
            r_pc_we   <= 1'b1;
          end
        end
        S_MEM: begin
          if (bus.mem_ack) begin
            if (w_is_sw) begin
              r_state       <= S_FETCH;
              r_instr_ready <= 1'b1;
            end else begin
              r_state      <= S_WB;
              r_reg_we     <= 1'b1;
              r_mem_to_reg <= 1'b1;
              r_pc_we      <= 1'b1;
            end
          end else if (w_timeout) begin
            r_state <= S_TRAP;
            r_trap  <= 1'b1;
          end else begin
            r_wait    <= r_wait + 1'b1;
            r_mem_req <= 1'b1;
            r_mem_we  <= w_is_sw;
          end
        end
        S_WB, S_BRANCH, S_JUMP: begin
          r_state       <= S_FETCH;
          r_instr_ready <= 1'b1;
        end
        S_TRAP: begin
          r_state <= S_TRAP;
        end
      endcase
    end
  end

  // Branch outcome and the sw ack strobe depend on same-cycle inputs, so they
  // bypass the output registers.
  assign w_sw_ack = (r_state == S_MEM) && w_is_sw && bus.mem_ack;
  assign w_pc_src = (r_state == S_BRANCH) ? (bus.alu_zero ? PC_BRANCH : PC_PLUS4)
                                          : r_pc_src;

  assign bus.instr_ready = r_instr_ready;
  assign bus.alu_op      = r_alu_op;
  assign bus.alu_src_b   = r_alu_src_b;
  assign bus.mem_req     = r_mem_req;
  assign bus.mem_we      = r_mem_we;
  assign bus.reg_we      = r_reg_we;
  assign bus.reg_dst     = r_reg_dst;
  assign bus.mem_to_reg  = r_mem_to_reg;
  assign bus.pc_we       = r_pc_we | w_sw_ack;
  assign bus.pc_src      = w_pc_src;
  assign bus.trap        = r_trap;

endmodule
